// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: response FSM encodings, the
// default starvation limit and a small decode helper. Also used by the SOC top.
package mem_arb_pkg;

  // Consecutive data grants tolerated while a fetch request is waiting.
  localparam int STARVE_MAX_DEF = 4;

  // Response FSM encodings: what was issued to the RAM in the previous cycle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_I_RD = 2'd1;
  localparam logic [1:0] ST_D_RD = 2'd2;
  localparam logic [1:0] ST_D_WR = 2'd3;

  // A data request with any byte lane enabled is a write.
  function automatic logic is_write(input logic [3:0] wmask);
    return |wmask;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle read
// latency. Data wins by default; a fetch that has watched STARVE_MAX data
// grants in a row gets the next slot. Grants and the RAM strobes are
// combinational, so one operation can issue every cycle while the previous
// read's data is being returned.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  // Instruction-fetch port (read-only)
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  // Data port (d_wmask == 0 is a read)
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // Single-port RAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

  logic [1:0] r_state;
  logic [2:0] r_starve_cnt;

  logic       w_starved;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_d_write;
  logic [1:0] w_state_nxt;
  logic [2:0] w_starve_nxt;

  // Priority: data first unless fetch has hit its starvation limit; no grants in reset.
  always_comb begin
    w_d_write = is_write(d_wmask);
    w_starved = i_req && (r_starve_cnt == LP_STARVE_MAX);
    w_d_gnt   = RESET && d_req && !w_starved;
    w_i_gnt   = RESET && i_req && !w_d_gnt;
  end

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  // Steer the winner onto the RAM port; everything idles at zero without a grant.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path can infer a latch.
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_rstrb = !w_d_write;
      mem_wmask = d_wmask;
      mem_wdata = d_wdata;
    end else if (w_i_gnt) begin
      mem_addr  = i_addr;
      mem_rstrb = 1'b1;
    end
  end

  // Next response state follows the operation issued this cycle.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_d_gnt) begin
      w_state_nxt = w_d_write ? ST_D_WR : ST_D_RD;
    end else if (w_i_gnt) begin
      w_state_nxt = ST_I_RD;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_req || w_i_gnt) begin
      w_starve_nxt = 3'd0;
    end else if (w_d_gnt) begin
      w_starve_nxt = r_starve_cnt + 3'd1;
    end
  end

  // Register issued operation and starvation count; reset drops any pending response.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Return read data to the port that issued it; data buses read zero when not valid.
  always_comb begin
    i_rvalid = (r_state == ST_I_RD);
    d_rvalid = (r_state == ST_D_RD);
    i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Scenario tasks drive requests on the
// falling edge and check grants and RAM strobes inline; each driven cycle
// pushes the expected read response, which a monitor pops one cycle later
// while it plays the RAM's read data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] data;
  } resp_t;

  logic          CLK;
  logic          RESET;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_wmask;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rstrb;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int    n_checks = 0;
  int    n_errors = 0;
  resp_t sb_q[$];

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // RAM side of the scoreboard: play the expected read data, then compare responses.
  always begin : monitor
    resp_t e;
    @(posedge CLK);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mem_rdata = e.data;
      #1;
      n_checks++;
      if (i_rvalid !== e.iv) begin
        n_errors++;
        $display("FAIL resp_i_rvalid @%0t: got %b expected %b", $time, i_rvalid, e.iv);
      end
      n_checks++;
      if (d_rvalid !== e.dv) begin
        n_errors++;
        $display("FAIL resp_d_rvalid @%0t: got %b expected %b", $time, d_rvalid, e.dv);
      end
      n_checks++;
      if (i_rdata !== (e.iv ? e.data : 32'd0)) begin
        n_errors++;
        $display("FAIL resp_i_rdata @%0t: got %h expected %h", $time, i_rdata, e.iv ? e.data : 32'd0);
      end
      n_checks++;
      if (d_rdata !== (e.dv ? e.data : 32'd0)) begin
        n_errors++;
        $display("FAIL resp_d_rdata @%0t: got %h expected %h", $time, d_rdata, e.dv ? e.data : 32'd0);
      end
    end
  end

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic [AW-1:0] da, input logic [3:0] dm, input logic [31:0] dw);
    @(negedge CLK);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_addr  = da;
    d_wmask = dm;
    d_wdata = dw;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20;
    d_wmask = 4'hF; d_wdata = 32'h1;
    for (int k = 0; k < 2; k++) begin
      #3;
      n_checks++;
      if ({i_gnt, d_gnt} !== 2'b00) begin
        n_errors++; $display("FAIL reset_gnt[%0d]: got %b expected 00", k, {i_gnt, d_gnt});
      end
      n_checks++;
      if ({mem_rstrb, mem_wmask} !== 5'b0) begin
        n_errors++; $display("FAIL reset_strobes[%0d]: got %b expected 00000", k, {mem_rstrb, mem_wmask});
      end
      n_checks++;
      if ({i_rvalid, d_rvalid} !== 2'b00) begin
        n_errors++; $display("FAIL reset_rvalid[%0d]: got %b expected 00", k, {i_rvalid, d_rvalid});
      end
      n_checks++;
      if (dut.r_state !== ST_IDLE || dut.r_starve_cnt !== 3'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got state %0d cnt %0d expected 0 0", k, dut.r_state, dut.r_starve_cnt);
      end
      @(posedge CLK);
    end
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    RESET = 1'b1;
  endtask

  task automatic test_fetch_single();
    drive(1'b1, 32'h10, 1'b0, '0, 4'h0, '0);
    #1;
    n_checks++;
    if ({i_gnt, d_gnt, mem_rstrb} !== 3'b101) begin
      n_errors++; $display("FAIL fetch_gnt: got i/d/rstrb %b expected 101", {i_gnt, d_gnt, mem_rstrb});
    end
    n_checks++;
    if (mem_addr !== 32'h10 || mem_wmask !== 4'h0) begin
      n_errors++; $display("FAIL fetch_mem: got addr %h wmask %b expected 10 0000", mem_addr, mem_wmask);
    end
    sb_q.push_back('{iv: 1'b1, dv: 1'b0, data: 32'hDEADBEEF});
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0001});
  endtask

  task automatic test_write();
    drive(1'b0, '0, 1'b1, 32'h40, 4'b0011, 32'h1234);
    #1;
    n_checks++;
    if ({i_gnt, d_gnt, mem_rstrb} !== 3'b010) begin
      n_errors++; $display("FAIL write_gnt: got i/d/rstrb %b expected 010", {i_gnt, d_gnt, mem_rstrb});
    end
    n_checks++;
    if (mem_wmask !== 4'b0011 || mem_wdata !== 32'h1234 || mem_addr !== 32'h40) begin
      n_errors++;
      $display("FAIL write_mem: got wmask %b wdata %h addr %h expected 0011 1234 40", mem_wmask, mem_wdata, mem_addr);
    end
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0002});
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    #1;
    n_checks++;
    if (dut.r_state !== ST_D_WR) begin
      n_errors++; $display("FAIL write_state: got %0d expected %0d", dut.r_state, ST_D_WR);
    end
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0003});
  endtask

  task automatic test_starve();
    logic [5:0] exp_i   = 6'b010000;
    logic [2:0] exp_cnt[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h200, 1'b1, 32'h300, 4'h0, '0);
      #1;
      n_checks++;
      if (dut.r_starve_cnt !== exp_cnt[k]) begin
        n_errors++; $display("FAIL starve_cnt[%0d]: got %0d expected %0d", k + 1, dut.r_starve_cnt, exp_cnt[k]);
      end
      n_checks++;
      if ({i_gnt, d_gnt} !== {exp_i[k], !exp_i[k]}) begin
        n_errors++;
        $display("FAIL starve_gnt[%0d]: got i/d %b expected %b", k + 1, {i_gnt, d_gnt}, {exp_i[k], !exp_i[k]});
      end
      n_checks++;
      if (mem_addr !== (exp_i[k] ? 32'h200 : 32'h300) || mem_rstrb !== 1'b1) begin
        n_errors++; $display("FAIL starve_mem[%0d]: got addr %h rstrb %b", k + 1, mem_addr, mem_rstrb);
      end
      sb_q.push_back('{iv: exp_i[k], dv: !exp_i[k], data: 32'hA000_0000 + k});
    end
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0004});
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      logic is_i = (k % 2 == 0);
      logic [AW-1:0] a = is_i ? (32'h400 + 4 * k) : (32'h500 + 4 * k);
      drive(is_i, 32'h400 + 4 * k, !is_i, 32'h500 + 4 * k, 4'h0, '0);
      #1;
      n_checks++;
      if ({i_gnt, d_gnt} !== {is_i, !is_i} || mem_addr !== a || mem_rstrb !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_grant[%0d]: got i/d %b addr %h rstrb %b expected %b %h 1",
                 k, {i_gnt, d_gnt}, mem_addr, mem_rstrb, {is_i, !is_i}, a);
      end
      sb_q.push_back('{iv: is_i, dv: !is_i, data: 32'hC000_0000 + k});
    end
  endtask

  task automatic test_same_addr();
    drive(1'b0, '0, 1'b1, 32'h80, 4'hF, 32'h5555_0000);
    #1;
    n_checks++;
    if (mem_wmask !== 4'hF || mem_rstrb !== 1'b0 || mem_addr !== 32'h80) begin
      n_errors++; $display("FAIL order_write: got wmask %b rstrb %b addr %h expected 1111 0 80", mem_wmask, mem_rstrb, mem_addr);
    end
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0005});
    drive(1'b0, '0, 1'b1, 32'h80, 4'h0, '0);
    #1;
    n_checks++;
    if (mem_wmask !== 4'h0 || mem_rstrb !== 1'b1 || mem_addr !== 32'h80) begin
      n_errors++; $display("FAIL order_read: got wmask %b rstrb %b addr %h expected 0000 1 80", mem_wmask, mem_rstrb, mem_addr);
    end
    sb_q.push_back('{iv: 1'b0, dv: 1'b1, data: 32'h5555_0000});
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h30, 1'b0, '0, 4'h0, '0);
      #1;
      n_checks++;
      if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
        n_errors++; $display("FAIL fetch_only_gnt[%0d]: got i/d %b expected 10", k, {i_gnt, d_gnt});
      end
      n_checks++;
      if (dut.r_starve_cnt !== 3'd0) begin
        n_errors++; $display("FAIL fetch_only_cnt[%0d]: got %0d expected 0", k, dut.r_starve_cnt);
      end
      sb_q.push_back('{iv: 1'b1, dv: 1'b0, data: 32'hF000_0000 + k});
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h20, 1'b0, '0, 4'h0, '0);
    #1;
    n_checks++;
    if (i_gnt !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_pre_gnt: got %b expected 1", i_gnt);
    end
    // The grant is cancelled by reset, so no response may appear.
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h5555_AAAA});
    #1 RESET = 1'b0;
    #1;
    n_checks++;
    if (i_gnt !== 1'b0 || mem_rstrb !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_gnt_async: got gnt %b rstrb %b expected 0 0", i_gnt, mem_rstrb);
    end
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    RESET = 1'b1;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || i_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_state: got state %0d i_rvalid %b expected 0 0", dut.r_state, i_rvalid);
    end
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0006});
    drive(1'b1, 32'h24, 1'b0, '0, 4'h0, '0);
    #1;
    n_checks++;
    if (i_gnt !== 1'b1 || mem_addr !== 32'h24) begin
      n_errors++; $display("FAIL rstmid_post_gnt: got gnt %b addr %h expected 1 24", i_gnt, mem_addr);
    end
    sb_q.push_back('{iv: 1'b1, dv: 1'b0, data: 32'h2424_2424});
    drive(1'b0, '0, 1'b0, '0, 4'h0, '0);
    sb_q.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0BAD_0007});
  endtask

  initial begin
    mem_rdata = 32'h0;
    test_reset();
    test_fetch_single();
    test_write();
    test_starve();
    test_back_to_back();
    test_same_addr();
    test_fetch_only();
    test_reset_mid();
    repeat (2) @(posedge CLK);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL drain: got %0d pending responses expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width of both requesters and the memory port.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive data grants allowed while a fetch request waits.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports i_req input 1, i_addr input ADDR_W, i_gnt output 1, i_rvalid output 1 and i_rdata output 32, forming the instruction-fetch port, which is read-only.
REQ-006 The block SHALL have ports d_req input 1, d_addr input ADDR_W, d_wmask input 4, d_wdata input 32, d_gnt output 1, d_rvalid output 1 and d_rdata output 32, forming the data port; d_wmask=0 means read and d_wmask≠0 means write.
REQ-007 The block SHALL have ports mem_addr output ADDR_W, mem_rstrb output 1, mem_wmask output 4, mem_wdata output 32 and mem_rdata input 32, connecting to a single-port RAM with fixed 1-cycle read latency.

Function
REQ-008 Requesters SHALL hold req, addr, wmask and wdata stable until gnt is sampled high; a request is consumed in the cycle req&&gnt is high.
REQ-009 gnt and the mem_* outputs SHALL be combinational from the current req and state, with at most one gnt high per cycle.
REQ-010 Default priority SHALL be data over fetch.
REQ-011 A 3-bit counter starve_cnt SHALL increment on each d_gnt while i_req is high, and SHALL clear on i_gnt or when i_req is low.
REQ-012 When starve_cnt==STARVE_MAX and both requests are high, i_gnt SHALL win.
REQ-013 On a grant, the mem port SHALL carry the winner's address: mem_rstrb=1 for a read, or mem_wmask/mem_wdata for a data write.
REQ-014 With no grant, mem_rstrb=0 and mem_wmask=0.
REQ-015 A response FSM SHALL register the issued operation each cycle with states IDLE, I_RD, D_RD and D_WR.
REQ-016 The next state SHALL be determined by the operation granted this cycle, or IDLE if none.
REQ-017 In state I_RD, i_rvalid=1 and i_rdata=mem_rdata; in D_RD, d_rvalid=1 and d_rdata=mem_rdata.
REQ-018 Read latency SHALL be exactly 1 cycle from grant to rvalid.
REQ-019 Writes SHALL produce no rvalid; they complete at grant, and D_WR exists only to block nothing and is observable for debug.
REQ-020 Grants SHALL be issuable every cycle, including while a response is returning, giving back-to-back throughput of 1 op/cycle.
REQ-021 i_rdata and d_rdata SHALL be 0 when their rvalid is low.
REQ-022 A read and a write to the same address in consecutive cycles SHALL be issued in grant order, with no reordering.

Reset
REQ-023 While RESET=0, state SHALL be IDLE, starve_cnt=0, i_rvalid=0, d_rvalid=0, i_gnt=0 and d_gnt=0, and all mem strobes SHALL be 0, independent of CLK.
REQ-024 A response pending when reset asserts SHALL be discarded and never delivered after release.
REQ-025 The first grant after reset release SHALL occur no earlier than the first rising CLK edge with RESET=1.

Structure
REQ-026 Response FSM state encodings and the STARVE_MAX default SHALL live in a shared package, mem_arb_pkg, also used by the SOC top.
REQ-027 The block SHALL be flat with no sub-module; the priority and starve logic SHALL stay inline.

Verification
REQ-028 The bench SHALL check: i_req alone with i_addr=0x10 and mem_rdata=0xDEADBEEF -> i_gnt same cycle, mem_rstrb=1, and i_rvalid=1 with i_rdata=0xDEADBEEF one cycle later.
REQ-029 The bench SHALL check: i_req and d_req (read) both held high for 6 cycles -> d_gnt on cycles 1-4, i_gnt on cycle 5, d_gnt on cycle 6.
REQ-030 The bench SHALL check: d_req with d_wmask=4'b0011 and d_wdata=0x1234 -> mem_wmask=0011 at grant, and d_rvalid stays 0 the next cycle.
REQ-031 The bench SHALL check: alternating i and d reads every cycle -> one grant per cycle, with rvalid routed to the correct port each following cycle and no bubbles.
REQ-032 The bench SHALL check: RESET driven low between the grant and response edge -> i_rvalid and d_rvalid stay 0, and state reads IDLE after release.
REQ-033 The bench SHALL check: i_req held with no d_req -> starve_cnt stays 0 and i_gnt is asserted every cycle.
